// File: rtl/i2c_reg_access.sv
// i2c_reg_access: sequences single-byte I2C register writes/reads into byte-level core operations.
module i2c_reg_access #(
  parameter logic [2:0] G_CMD_START   = 3'd1,
  parameter logic [2:0] G_CMD_RESTART = 3'd2,
  parameter logic [2:0] G_CMD_STOP    = 3'd3,
  parameter logic [2:0] G_CMD_TXBYTE  = 3'd4,
  parameter logic [2:0] G_CMD_RXBYTE  = 3'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic       rnw_i,
  input  logic [6:0] dev_adr_i,
  input  logic [7:0] reg_adr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  output logic [2:0] core_cmd_o,
  output logic       core_start_o,
  output logic [7:0] core_txd_o,
  output logic       core_txack_o,
  input  logic       core_done_i,
  input  logic       core_rxack_i,
  input  logic [7:0] core_rxd_i
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t     state;
  logic [2:0] step, nxt, ncmd;
  logic [7:0] ntxd, radr, wdat, rbuf;
  logic [6:0] dev;
  logic       rnw, err, nack;
  assign core_txack_o = 1'b1;
  assign nack = core_cmd_o == G_CMD_TXBYTE && core_rxack_i;
  // a NACK skips straight to the closing STOP so the bus is never left open
  assign nxt = nack ? (rnw ? 3'd6 : 3'd4) : step + 3'd1;
  always_comb begin
    ncmd = G_CMD_TXBYTE;
    ntxd = 8'h00;
    case ({rnw, nxt})
      4'b0_001, 4'b1_001: ntxd = {dev, 1'b0};
      4'b0_010, 4'b1_010: ntxd = radr;
      4'b0_011: ntxd = wdat;
      4'b1_011: ncmd = G_CMD_RESTART;
      4'b1_100: ntxd = {dev, 1'b1};
      4'b1_101: ncmd = G_CMD_RXBYTE;
      default: ncmd = G_CMD_STOP;
    endcase
  end
  // outputs are loaded on the transition into a state so they are valid during it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      step <= '0;
      rnw <= 1'b0;
      dev <= '0;
      radr <= '0;
      wdat <= '0;
      rbuf <= '0;
      err <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      rdata_o <= '0;
      core_cmd_o <= '0;
      core_start_o <= 1'b0;
      core_txd_o <= '0;
    end else begin
      core_start_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        S_IDLE: if (req_i) begin
          rnw <= rnw_i;
          dev <= dev_adr_i;
          radr <= reg_adr_i;
          wdat <= wdata_i;
          step <= '0;
          err <= 1'b0;
          err_o <= 1'b0;
          busy_o <= 1'b1;
          core_cmd_o <= G_CMD_START;
          core_txd_o <= '0;
          core_start_o <= 1'b1;
          state <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (core_done_i) begin
          if (core_cmd_o == G_CMD_STOP) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            err_o <= err;
            if (!err && rnw) rdata_o <= rbuf;
            state <= S_DONE;
          end else begin
            if (nack) err <= 1'b1;
            if (core_cmd_o == G_CMD_RXBYTE) rbuf <= core_rxd_i;
            step <= nxt;
            core_cmd_o <= ncmd;
            core_txd_o <= ntxd;
            core_start_o <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_i2c_reg_access.sv
// tb_i2c_reg_access: scoreboard bench with a behavioural core/slave model for i2c_reg_access.
module tb_i2c_reg_access;
  localparam logic [2:0] C_START = 3'd1, C_RESTART = 3'd2, C_STOP = 3'd3, C_TX = 3'd4, C_RX = 3'd5;
  typedef struct packed {logic [2:0] cmd; logic [7:0] txd;} op_t;
  typedef struct packed {logic err; logic [7:0] rd;} res_t;
  logic       clk, rst, req_i, rnw_i;
  logic [6:0] dev_adr_i;
  logic [7:0] reg_adr_i, wdata_i, rdata_o, core_txd_o, core_rxd_i;
  logic       busy_o, done_o, err_o, core_start_o, core_txack_o, core_done_i, core_rxack_i;
  logic [2:0] core_cmd_o;
  int n_cmp = 0, n_err = 0, n_done = 0, cyc = 0, done_cyc = 0, t0 = 0;
  int op_idx = 0, nack_at = -1, dly = 1;
  bit junk = 0;
  logic [7:0] slave_data = 8'h00, model_rdata = 8'h00;
  op_t  op_q[$];
  res_t res_q[$];

  i2c_reg_access dut (
    .clk(clk), .rst(rst), .req_i(req_i), .rnw_i(rnw_i), .dev_adr_i(dev_adr_i),
    .reg_adr_i(reg_adr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .core_cmd_o(core_cmd_o), .core_start_o(core_start_o),
    .core_txd_o(core_txd_o), .core_txack_o(core_txack_o), .core_done_i(core_done_i),
    .core_rxack_i(core_rxack_i), .core_rxd_i(core_rxd_i)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ops(input bit r, input logic [6:0] dv, input logic [7:0] rg, input logic [7:0] wd, input int nk);
    op_t seq[$];
    seq.push_back({C_START, 8'h00});
    seq.push_back({C_TX, {dv, 1'b0}});
    seq.push_back({C_TX, rg});
    if (!r) seq.push_back({C_TX, wd});
    else begin
      seq.push_back({C_RESTART, 8'h00});
      seq.push_back({C_TX, {dv, 1'b1}});
      seq.push_back({C_RX, 8'h00});
    end
    seq.push_back({C_STOP, 8'h00});
    for (int i = 0; i < seq.size(); i++)
      if (nk < 0 || i <= nk) op_q.push_back(seq[i]);
    if (nk >= 0) op_q.push_back({C_STOP, 8'h00});
  endtask

  task automatic push_res(input bit r, input int nk);
    if (nk < 0 && r) model_rdata = slave_data;
    res_q.push_back({nk >= 0, model_rdata});
  endtask

  task automatic wait_done(input int tgt);
    for (int i = 0; i < 400 && n_done < tgt; i++) @(posedge clk);
    check("done_timeout", 32'(n_done >= tgt), 1);
  endtask

  task automatic drive_req(input bit r, input logic [6:0] dv, input logic [7:0] rg, input logic [7:0] wd);
    @(posedge clk); #1;
    req_i = 1; rnw_i = r; dev_adr_i = dv; reg_adr_i = rg; wdata_i = wd;
    @(posedge clk); #1;
    t0 = cyc;
    req_i = 0;
    check("busy_acc", busy_o, 1);
    check("err_clr_acc", err_o, 0);
  endtask

  task automatic run_txn(input bit r, input logic [6:0] dv, input logic [7:0] rg, input logic [7:0] wd,
                         input int nk, input int d, input logic [7:0] sd, input bit jk);
    int tgt;
    dly = d; nack_at = nk; slave_data = sd; junk = jk;
    push_ops(r, dv, rg, wd, nk);
    push_res(r, nk);
    op_idx = 0;
    tgt = n_done + 1;
    drive_req(r, dv, rg, wd);
    wait_done(tgt);
  endtask

  // core + slave model: checks each issued op against the scoreboard and answers after dly cycles
  initial begin
    core_done_i = 0; core_rxack_i = 0; core_rxd_i = 0;
    forever begin
      @(negedge clk);
      if (core_start_o && !rst) begin
        op_t e;
        int idx;
        idx = op_idx;
        op_idx++;
        check("op_avail", 32'(op_q.size() > 0), 1);
        e = '0;
        if (op_q.size() > 0) begin
          e = op_q.pop_front();
          check("cmd", core_cmd_o, e.cmd);
          check("txd", core_txd_o, e.txd);
        end
        if (e.cmd == C_RX) check("txack_rx", core_txack_o, 1);
        @(posedge clk); #1;
        for (int j = 0; j < dly; j++) begin
          if (j > 0) begin
            @(posedge clk); #1;
          end
          if (!rst) begin
            check("no_start_wait", core_start_o, 0);
            check("txd_hold", core_txd_o, e.txd);
          end
        end
        core_done_i = 1;
        core_rxack_i = (idx == nack_at) || (e.cmd != C_TX && junk);
        core_rxd_i = (e.cmd == C_RX) ? slave_data : 8'($urandom);
        @(posedge clk); #1;
        core_done_i = 0;
        core_rxack_i = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_o && !rst) begin
      res_t r;
      n_done++;
      done_cyc = cyc;
      check("busy_at_done", busy_o, 0);
      check("cmd_at_done", core_cmd_o, C_STOP);
      check("res_avail", 32'(res_q.size() > 0), 1);
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        check("err", err_o, r.err);
        check("rdata", rdata_o, r.rd);
      end
    end
  end

  initial begin
    int tgt;
    rst = 0; req_i = 0; rnw_i = 0; dev_adr_i = 0; reg_adr_i = 0; wdata_i = 0;
    #2 rst = 1;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_cmd", core_cmd_o, 0);
    check("rst_start", core_start_o, 0);
    check("rst_txd", core_txd_o, 0);
    check("rst_txack", core_txack_o, 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    run_txn(0, 7'h50, 8'h10, 8'hA5, -1, 1, 8'h00, 0);
    check("latency", done_cyc - t0, 10);
    run_txn(1, 7'h50, 8'h3C, 8'h00, -1, 2, 8'h5A, 1);
    run_txn(1, 7'h50, 8'h3C, 8'h00, 1, 1, 8'h77, 0);
    run_txn(0, 7'h50, 8'h10, 8'hA5, 3, 2, 8'h00, 0);
    run_txn(0, 7'h51, 8'h20, 8'h3E, -1, 1, 8'h00, 0);
    dly = 1; nack_at = -1; slave_data = 8'hC3; junk = 0;
    push_ops(1, 7'h2A, 8'h77, 8'h00, -1);
    push_res(1, -1);
    push_ops(1, 7'h2A, 8'h77, 8'h00, -1);
    push_res(1, -1);
    op_idx = 0;
    tgt = n_done + 1;
    @(posedge clk); #1;
    req_i = 1; rnw_i = 1; dev_adr_i = 7'h2A; reg_adr_i = 8'h77; wdata_i = 8'h00;
    wait_done(tgt);
    check("one_txn", n_done, tgt);
    @(posedge clk); #1;
    req_i = 0;
    check("second_busy", busy_o, 1);
    wait_done(tgt + 1);
    repeat (3) @(posedge clk);
    check("no_third", n_done, tgt + 1);
    dly = 3;
    push_ops(0, 7'h22, 8'h33, 8'h44, -1);
    op_idx = 0;
    tgt = n_done;
    drive_req(0, 7'h22, 8'h33, 8'h44);
    for (int i = 0; i < 100 && op_idx < 3; i++) @(posedge clk);
    @(posedge clk); #3;
    rst = 1;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_err", err_o, 0);
    check("arst_rdata", rdata_o, 0);
    check("arst_cmd", core_cmd_o, 0);
    check("arst_start", core_start_o, 0);
    check("arst_txd", core_txd_o, 0);
    check("arst_txack", core_txack_o, 1);
    repeat (5) @(posedge clk);
    op_q.delete();
    model_rdata = 8'h00;
    check("arst_no_done", n_done, tgt);
    #1 rst = 0;
    run_txn(0, 7'h50, 8'h11, 8'h5C, -1, 1, 8'h00, 0);
    repeat (3) @(posedge clk);
    check("ops_left", op_q.size(), 0);
    check("res_left", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
